// File: rtl/gpio_arbiter.sv
// Two-master round-robin arbiter in front of a single GPIO register slave.
// One transaction in flight at a time; the last grantee may hold the slave with m_lock.
module gpio_arbiter #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_read_i,
    input  logic              m0_write_i,
    input  logic              m0_lock_i,
    input  logic [ADDR_W-1:0] m0_address_i,
    input  logic [DATA_W-1:0] m0_writedata_i,
    output logic              m0_waitrequest_o,
    output logic              m0_readdatavalid_o,
    output logic [DATA_W-1:0] m0_readdata_o,

    input  logic              m1_read_i,
    input  logic              m1_write_i,
    input  logic              m1_lock_i,
    input  logic [ADDR_W-1:0] m1_address_i,
    input  logic [DATA_W-1:0] m1_writedata_i,
    output logic              m1_waitrequest_o,
    output logic              m1_readdatavalid_o,
    output logic [DATA_W-1:0] m1_readdata_o,

    output logic              s_chipselect_o,
    output logic              s_write_n_o,
    output logic [ADDR_W-1:0] s_address_o,
    output logic [DATA_W-1:0] s_writedata_o,
    input  logic [DATA_W-1:0] s_readdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t              state_q;
    logic                gnt_q;
    logic                last_gnt_q;
    logic                rvalid_q;
    logic                cs_q;
    logic                write_n_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                req0;
    logic                req1;
    logic                last_lock;
    logic                gnt_d;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                issue0;
    logic                issue1;

    assign req0      = m0_read_i | m0_write_i;
    assign req1      = m1_read_i | m1_write_i;
    assign last_lock = last_gnt_q ? m1_lock_i : m0_lock_i;

    // Round-robin pick; a locking last grantee keeps the slave under contention.
    always_comb begin
        gnt_d = last_gnt_q;
        if (req0 && req1) begin
            gnt_d = last_lock ? last_gnt_q : ~last_gnt_q;
        end else begin
            gnt_d = req1;
        end
    end

    assign cmd_write = gnt_d ? m1_write_i     : m0_write_i;
    assign cmd_addr  = gnt_d ? m1_address_i   : m0_address_i;
    assign cmd_wdata = gnt_d ? m1_writedata_i : m0_writedata_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            rvalid_q   <= 1'b0;
            cs_q       <= 1'b0;
            write_n_q  <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rvalid_q <= 1'b0;
                    if (req0 || req1) begin
                        gnt_q     <= gnt_d;
                        cs_q      <= 1'b1;
                        write_n_q <= ~cmd_write;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    last_gnt_q <= gnt_q;
                    cs_q       <= 1'b0;
                    write_n_q  <= 1'b1;
                    addr_q     <= '0;
                    wdata_q    <= '0;
                    rvalid_q   <= write_n_q;
                    state_q    <= write_n_q ? RDATA : IDLE;
                end
                RDATA: begin
                    rvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    rvalid_q  <= 1'b0;
                    cs_q      <= 1'b0;
                    write_n_q <= 1'b1;
                    addr_q    <= '0;
                    wdata_q   <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign issue0 = (state_q == ISSUE) && !gnt_q;
    assign issue1 = (state_q == ISSUE) &&  gnt_q;

    // Reset masks every response so an aborted read never surfaces.
    assign m0_waitrequest_o   = req0 && !issue0 && !reset;
    assign m1_waitrequest_o   = req1 && !issue1 && !reset;
    assign m0_readdatavalid_o = rvalid_q && !gnt_q && !reset;
    assign m1_readdatavalid_o = rvalid_q &&  gnt_q && !reset;
    assign m0_readdata_o      = m0_readdatavalid_o ? s_readdata_i : '0;
    assign m1_readdata_o      = m1_readdatavalid_o ? s_readdata_i : '0;

    assign s_chipselect_o = cs_q && !reset;
    assign s_write_n_o    = write_n_q || reset;
    assign s_address_o    = reset ? '0 : addr_q;
    assign s_writedata_o  = reset ? '0 : wdata_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Scoreboard bench for gpio_arbiter: expected slave accesses and read returns are queued
// as stimulus is driven and checked when the DUT produces them; each test adds cycle checks.
module tb_gpio_arbiter;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_read, m0_write, m0_lock;
    logic [AW-1:0] m0_address;
    logic [DW-1:0] m0_writedata;
    logic          m0_wait, m0_rdv;
    logic [DW-1:0] m0_readdata;
    logic          m1_read, m1_write, m1_lock;
    logic [AW-1:0] m1_address;
    logic [DW-1:0] m1_writedata;
    logic          m1_wait, m1_rdv;
    logic [DW-1:0] m1_readdata;
    logic          s_cs, s_wn;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          mst;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t rd_q[$];
    logic [DW-1:0] mem [4];

    always #5 clk = ~clk;

    gpio_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                (clk),
        .reset              (reset),
        .m0_read_i          (m0_read),
        .m0_write_i         (m0_write),
        .m0_lock_i          (m0_lock),
        .m0_address_i       (m0_address),
        .m0_writedata_i     (m0_writedata),
        .m0_waitrequest_o   (m0_wait),
        .m0_readdatavalid_o (m0_rdv),
        .m0_readdata_o      (m0_readdata),
        .m1_read_i          (m1_read),
        .m1_write_i         (m1_write),
        .m1_lock_i          (m1_lock),
        .m1_address_i       (m1_address),
        .m1_writedata_i     (m1_writedata),
        .m1_waitrequest_o   (m1_wait),
        .m1_readdatavalid_o (m1_rdv),
        .m1_readdata_o      (m1_readdata),
        .s_chipselect_o     (s_cs),
        .s_write_n_o        (s_wn),
        .s_address_o        (s_addr),
        .s_writedata_o      (s_wdata),
        .s_readdata_i       (s_rdata)
    );

    // Register-file slave with one-cycle registered read data.
    always @(posedge clk) begin
        if (reset) begin
            mem[0]  <= 32'h0;
            mem[1]  <= 32'h0000_00FF;
            mem[2]  <= 32'h1234_5678;
            mem[3]  <= 32'h0;
            s_rdata <= 32'h0;
        end else begin
            if (s_cs && !s_wn) mem[s_addr] <= s_wdata;
            s_rdata <= mem[s_addr];
        end
    end

    // Scoreboard monitor: slave accesses and read returns against queued expectations.
    always @(negedge clk) begin
        logic a0, a1;
        exp_t e;
        if (!reset) begin
            a0 = (m0_read | m0_write) & ~m0_wait;
            a1 = (m1_read | m1_write) & ~m1_wait;
            if (s_cs) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: slave access addr=%0h wn=%0b with nothing expected", s_addr, s_wn);
                end else begin
                    e = sb_q.pop_front();
                    total++;
                    if ({a1, a0} !== (e.mst ? 2'b10 : 2'b01)) begin
                        bad++;
                        $display("FAIL sb_grantee: accepted={m1,m0}=%b want master %0d", {a1, a0}, e.mst);
                    end
                    total++;
                    if (s_wn !== ~e.wr) begin
                        bad++;
                        $display("FAIL sb_write_n: got %b want %b", s_wn, ~e.wr);
                    end
                    total++;
                    if (s_addr !== e.addr) begin
                        bad++;
                        $display("FAIL sb_address: got %0h want %0h", s_addr, e.addr);
                    end
                    if (e.wr) begin
                        total++;
                        if (s_wdata !== e.wdata) begin
                            bad++;
                            $display("FAIL sb_writedata: got %h want %h", s_wdata, e.wdata);
                        end
                    end else begin
                        rd_q.push_back(e);
                    end
                end
            end
            if (m0_rdv || m1_rdv) begin
                total++;
                if (rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_unexpected: readdatavalid m0=%b m1=%b with no read pending", m0_rdv, m1_rdv);
                end else begin
                    e = rd_q.pop_front();
                    total++;
                    if ({m1_rdv, m0_rdv} !== (e.mst ? 2'b10 : 2'b01)) begin
                        bad++;
                        $display("FAIL rd_master: rdv={m1,m0}=%b want master %0d", {m1_rdv, m0_rdv}, e.mst);
                    end
                    total++;
                    if ((e.mst ? m1_readdata : m0_readdata) !== e.rdata) begin
                        bad++;
                        $display("FAIL rd_data: got %h want %h", e.mst ? m1_readdata : m0_readdata, e.rdata);
                    end
                end
            end
            if (!m0_rdv) begin
                total++;
                if (m0_readdata !== '0) begin
                    bad++;
                    $display("FAIL m0_readdata_idle: got %h want 0", m0_readdata);
                end
            end
            if (!m1_rdv) begin
                total++;
                if (m1_readdata !== '0) begin
                    bad++;
                    $display("FAIL m1_readdata_idle: got %h want 0", m1_readdata);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic rd, input logic wr, input logic lk,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_read = rd; m0_write = wr; m0_lock = lk; m0_address = a; m0_writedata = d;
    endtask

    task automatic drive_m1(input logic rd, input logic wr, input logic lk,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_read = rd; m1_write = wr; m1_lock = lk; m1_address = a; m1_writedata = d;
    endtask

    task automatic idle_all;
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0);
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic exp_t mk(input logic mst, input logic wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        exp_t e;
        e.mst = mst; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd;
        return e;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        drive_m0(1'b1, 1'b0, 1'b0, 2'd1, 32'h0);
        drive_m1(1'b0, 1'b1, 1'b0, 2'd2, 32'h5);
        repeat (2) tick;
        @(negedge clk);
        total++;
        if ({m0_wait, m1_wait, m0_rdv, m1_rdv, s_cs, s_wn} !== 6'b000001) begin
            bad++;
            $display("FAIL rst_ctrl: {w0,w1,v0,v1,cs,wn}=%b want 000001", {m0_wait, m1_wait, m0_rdv, m1_rdv, s_cs, s_wn});
        end
        total++;
        if ({m0_readdata, m1_readdata, s_addr, s_wdata} !== '0) begin
            bad++;
            $display("FAIL rst_data: rd0=%h rd1=%h addr=%h wd=%h want all 0", m0_readdata, m1_readdata, s_addr, s_wdata);
        end
        tick;
        idle_all;
        reset = 1'b0;
        tick;
        @(negedge clk);
        total++;
        if ({m0_wait, m1_wait, s_cs, s_wn} !== 4'b0001) begin
            bad++;
            $display("FAIL post_rst_idle: {w0,w1,cs,wn}=%b want 0001", {m0_wait, m1_wait, s_cs, s_wn});
        end
    endtask

    task automatic test_single_write;
        tick;
        sb_q.push_back(mk(1'b0, 1'b1, 2'd0, 32'hA5A5_0001, 32'h0));
        drive_m0(1'b0, 1'b1, 1'b0, 2'd0, 32'hA5A5_0001);
        @(negedge clk);
        total++;
        if ({m0_wait, s_cs} !== 2'b10) begin
            bad++;
            $display("FAIL wr_c0: {wait,cs}=%b want 10", {m0_wait, s_cs});
        end
        tick;
        @(negedge clk);
        total++;
        if ({m0_wait, s_cs, s_wn} !== 3'b010) begin
            bad++;
            $display("FAIL wr_c1: {wait,cs,wn}=%b want 010", {m0_wait, s_cs, s_wn});
        end
        tick;
        idle_all;
        @(negedge clk);
        total++;
        if ({m0_wait, s_cs, s_wn, m0_rdv} !== 4'b0010) begin
            bad++;
            $display("FAIL wr_c2: {wait,cs,wn,rdv}=%b want 0010", {m0_wait, s_cs, s_wn, m0_rdv});
        end
    endtask

    task automatic test_single_read;
        tick;
        sb_q.push_back(mk(1'b1, 1'b0, 2'd1, 32'h0, 32'h0000_00FF));
        drive_m1(1'b1, 1'b0, 1'b0, 2'd1, 32'h0);
        @(negedge clk);
        total++;
        if (m1_wait !== 1'b1) begin
            bad++;
            $display("FAIL rd_c0_wait: got %b want 1", m1_wait);
        end
        tick;
        @(negedge clk);
        total++;
        if ({m1_wait, s_cs, s_wn, m1_rdv} !== 4'b0110) begin
            bad++;
            $display("FAIL rd_c1: {wait,cs,wn,rdv}=%b want 0110", {m1_wait, s_cs, s_wn, m1_rdv});
        end
        tick;
        idle_all;
        @(negedge clk);
        total++;
        if ({m1_rdv, m0_rdv, s_cs} !== 3'b100 || m1_readdata !== 32'h0000_00FF) begin
            bad++;
            $display("FAIL rd_c2: {v1,v0,cs}=%b data=%h want 100 data=000000ff", {m1_rdv, m0_rdv, s_cs}, m1_readdata);
        end
        tick;
        @(negedge clk);
        total++;
        if (m1_rdv !== 1'b0) begin
            bad++;
            $display("FAIL rd_c3_rdv: got %b want 0", m1_rdv);
        end
    endtask

    // m1 requests while m0's read is in flight; it is held off and served afterwards.
    task automatic test_holdoff;
        tick;
        sb_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, 32'hA5A5_0001));
        sb_q.push_back(mk(1'b1, 1'b1, 2'd2, 32'hCAFE_0002, 32'h0));
        drive_m0(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        tick;
        drive_m1(1'b0, 1'b1, 1'b0, 2'd2, 32'hCAFE_0002);
        @(negedge clk);
        total++;
        if ({m0_wait, m1_wait} !== 2'b01) begin
            bad++;
            $display("FAIL hold_c1: {w0,w1}=%b want 01", {m0_wait, m1_wait});
        end
        tick;
        drive_m0(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        total++;
        if ({m0_rdv, m1_wait} !== 2'b11 || m0_readdata !== 32'hA5A5_0001) begin
            bad++;
            $display("FAIL hold_c2: {v0,w1}=%b data=%h want 11 data=a5a50001", {m0_rdv, m1_wait}, m0_readdata);
        end
        tick;
        @(negedge clk);
        total++;
        if ({m1_wait, s_cs} !== 2'b10) begin
            bad++;
            $display("FAIL hold_c3: {w1,cs}=%b want 10", {m1_wait, s_cs});
        end
        tick;
        @(negedge clk);
        total++;
        if ({m1_wait, s_cs} !== 2'b01) begin
            bad++;
            $display("FAIL hold_c4: {w1,cs}=%b want 01", {m1_wait, s_cs});
        end
        tick;
        idle_all;
    endtask

    task automatic test_contention;
        int i0 = 0;
        int i1 = 0;
        logic a0, a1;
        logic [1:0] want;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back(mk(1'b0, 1'b1, 2'd2, 32'h1000_0000 + DW'(k), 32'h0));
            sb_q.push_back(mk(1'b1, 1'b1, 2'd3, 32'h2000_0000 + DW'(k), 32'h0));
        end
        drive_m0(1'b0, 1'b1, 1'b0, 2'd2, 32'h1000_0000);
        drive_m1(1'b0, 1'b1, 1'b0, 2'd3, 32'h2000_0000);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a0 = (m0_read | m0_write) & ~m0_wait;
            a1 = (m1_read | m1_write) & ~m1_wait;
            want = (c % 2 == 0) ? 2'b00 : (((c / 2) % 2 == 0) ? 2'b01 : 2'b10);
            total++;
            if ({a1, a0} !== want) begin
                bad++;
                $display("FAIL contention_c%0d: accepted={m1,m0}=%b want %b", c, {a1, a0}, want);
            end
            tick;
            if (a0) begin
                i0++;
                if (i0 < 2) m0_writedata = 32'h1000_0000 + DW'(i0);
                else drive_m0(1'b0, 1'b0, 1'b0, '0, '0);
            end
            if (a1) begin
                i1++;
                if (i1 < 2) m1_writedata = 32'h2000_0000 + DW'(i1);
                else drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
            end
        end
        idle_all;
    endtask

    task automatic test_lock;
        int i0 = 0;
        logic a0, a1;
        logic [1:0] want;
        logic [1:0] order [5];
        order[0] = 2'b01; order[1] = 2'b01; order[2] = 2'b01; order[3] = 2'b10; order[4] = 2'b01;
        tick;
        for (int k = 0; k < 3; k++) sb_q.push_back(mk(1'b0, 1'b1, 2'd0, 32'h3000_0000 + DW'(k), 32'h0));
        sb_q.push_back(mk(1'b1, 1'b1, 2'd1, 32'h4000_0000, 32'h0));
        sb_q.push_back(mk(1'b0, 1'b1, 2'd0, 32'h3000_0003, 32'h0));
        drive_m0(1'b0, 1'b1, 1'b1, 2'd0, 32'h3000_0000);
        drive_m1(1'b0, 1'b1, 1'b0, 2'd1, 32'h4000_0000);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            a0 = (m0_read | m0_write) & ~m0_wait;
            a1 = (m1_read | m1_write) & ~m1_wait;
            want = (c % 2 == 0) ? 2'b00 : order[c / 2];
            total++;
            if ({a1, a0} !== want) begin
                bad++;
                $display("FAIL lock_c%0d: accepted={m1,m0}=%b want %b", c, {a1, a0}, want);
            end
            tick;
            if (a0) begin
                i0++;
                if (i0 < 3) m0_writedata = 32'h3000_0000 + DW'(i0);
                else if (i0 == 3) drive_m0(1'b0, 1'b1, 1'b0, 2'd0, 32'h3000_0003);
                else drive_m0(1'b0, 1'b0, 1'b0, '0, '0);
            end
            if (a1) drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
        end
        idle_all;
    endtask

    task automatic test_reset_mid_read;
        tick;
        sb_q.push_back(mk(1'b1, 1'b0, 2'd1, 32'h0, 32'h0000_00FF));
        drive_m1(1'b1, 1'b0, 1'b0, 2'd1, 32'h0);
        tick;
        @(negedge clk);
        total++;
        if ({m1_wait, s_cs} !== 2'b01) begin
            bad++;
            $display("FAIL rstrd_c1: {w1,cs}=%b want 01", {m1_wait, s_cs});
        end
        tick;
        idle_all;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({m0_rdv, m1_rdv} !== 2'b00 || m1_readdata !== '0) begin
            bad++;
            $display("FAIL rstrd_c2: {v0,v1}=%b data=%h want 00 data=0", {m0_rdv, m1_rdv}, m1_readdata);
        end
        total++;
        if (rd_q.size() != 1) begin
            bad++;
            $display("FAIL rstrd_pending: got %0d pending reads want 1", rd_q.size());
        end
        rd_q.delete();
        tick;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({s_cs, s_wn, m1_rdv} !== 3'b010 || s_addr !== '0 || s_wdata !== '0) begin
            bad++;
            $display("FAIL rstrd_c3: {cs,wn,v1}=%b addr=%h wd=%h want 010 0 0", {s_cs, s_wn, m1_rdv}, s_addr, s_wdata);
        end
        tick;
        sb_q.push_back(mk(1'b1, 1'b0, 2'd1, 32'h0, 32'h0000_00FF));
        drive_m1(1'b1, 1'b0, 1'b0, 2'd1, 32'h0);
        repeat (2) tick;
        idle_all;
        @(negedge clk);
        total++;
        if (m1_rdv !== 1'b1 || m1_readdata !== 32'h0000_00FF) begin
            bad++;
            $display("FAIL rstrd_fresh: v1=%b data=%h want 1 000000ff", m1_rdv, m1_readdata);
        end
    endtask

    task automatic test_rw_both;
        tick;
        sb_q.push_back(mk(1'b0, 1'b1, 2'd3, 32'h5555_AAAA, 32'h0));
        drive_m0(1'b1, 1'b1, 1'b0, 2'd3, 32'h5555_AAAA);
        tick;
        @(negedge clk);
        total++;
        if ({s_cs, s_wn, m0_wait} !== 3'b100) begin
            bad++;
            $display("FAIL rw_c1: {cs,wn,w0}=%b want 100", {s_cs, s_wn, m0_wait});
        end
        tick;
        idle_all;
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (m0_rdv !== 1'b0) begin
                bad++;
                $display("FAIL rw_c%0d_rdv: got %b want 0", c, m0_rdv);
            end
            tick;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_all;
        test_reset;
        test_single_write;
        test_single_read;
        test_holdoff;
        test_contention;
        test_lock;
        test_reset_mid_read;
        test_rw_both;
        repeat (3) tick;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d slave accesses never seen", sb_q.size());
        end
        total++;
        if (rd_q.size() != 0) begin
            bad++;
            $display("FAIL rd_leftover: %0d read returns never seen", rd_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
